// File: rtl/e203_sysmem_icb_ram_pkg.sv
// Shared definitions for the sysmem ICB RAM slave.
//   ICB_DW / ICB_MW : ICB data width and byte-mask width.
//   RSP_W           : width of one response entry {err, rdata}.
//   rsp_entry_t     : packed response entry as held in the response FIFO.
//   ptr_w()         : pointer width for a FIFO of a given depth (at least 1 bit).
package e203_sysmem_icb_ram_pkg;

    localparam int ICB_DW = 32;
    localparam int ICB_MW = ICB_DW / 8;
    localparam int RSP_W  = ICB_DW + 1;

    typedef struct packed {
        logic              err;
        logic [ICB_DW-1:0] rdata;
    } rsp_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/e203_sysmem_ram_sp.sv
// Single-port inferred RAM, one byte lane per generate iteration.
//   clk  : clock
//   cs   : chip select; nothing happens when low
//   we   : 1 = write (byte lanes selected by wem), 0 = read
//   wem  : byte write enables
//   addr : word address
//   din  : write data
//   dout : read data, valid one edge after a read access; holds otherwise
// The contents and the output register are not reset.
module e203_sysmem_ram_sp
    import e203_sysmem_icb_ram_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic [ICB_MW-1:0] wem,
    input  logic [AW-1:0]     addr,
    input  logic [ICB_DW-1:0] din,
    output logic [ICB_DW-1:0] dout
);

    localparam int DEPTH = 1 << AW;

    // Separate byte-wide arrays map cleanly onto byte-enable block RAM.
    generate
        for (genvar gi = 0; gi < ICB_MW; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] dout_q;

            always_ff @(posedge clk) begin
                if (cs) begin
                    if (we) begin
                        if (wem[gi]) begin
                            mem[addr] <= din[8*gi +: 8];
                        end
                    end else begin
                        dout_q <= mem[addr];
                    end
                end
            end

            assign dout[8*gi +: 8] = dout_q;
        end
    endgenerate

endmodule

// File: rtl/e203_sysmem_icb_ram.sv
// ICB slave RAM on the SoC sysmem port.
//   clk, rst          : clock, asynchronous active-high reset
//   icb_cmd_*         : command channel (valid/ready, addr, read, wdata, wmask)
//   icb_rsp_*         : response channel (valid/ready, err, rdata)
// Commands are accepted while fewer than RSP_DEPTH responses are outstanding.
// Each accepted command occupies a one-entry pending stage for one cycle
// (while the RAM read completes) and then either goes straight out, if the
// FIFO is empty and the master is ready, or is parked in the response FIFO.
// Responses therefore appear one cycle after acceptance at the earliest and
// always in command order.
// Optional feature: define E203_SYSMEM_ADDR_CHK_EN to flag commands outside
// [BASE_ADDR, BASE_ADDR + 4*2^RAM_AW) with rsp_err=1 and suppress their writes.
module e203_sysmem_icb_ram
    import e203_sysmem_icb_ram_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            RAM_AW    = 14,
    parameter int            RSP_DEPTH = 2,
    parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [ICB_MW-1:0] icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic              icb_rsp_err,
    output logic [ICB_DW-1:0] icb_rsp_rdata
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = ptr_w(RSP_DEPTH);

    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          pend_q, pend_d;
    logic          pend_read_q, pend_read_d;
    logic          pend_err_q, pend_err_d;

    rsp_entry_t    fifo_mem [RSP_DEPTH];
    rsp_entry_t    pend_entry;
    rsp_entry_t    head_entry;

    logic              cmd_fire;
    logic              rsp_fire;
    logic              addr_err;
    logic              ram_we;
    logic [ICB_DW-1:0] ram_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;

    // Credit is a flop, so cmd_ready never depends combinationally on rsp_ready.
    assign icb_cmd_ready = (credit_q < CW'(RSP_DEPTH));
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;

`ifdef E203_SYSMEM_ADDR_CHK_EN
    // One extra bit so the window end cannot wrap at the top of the address space.
    localparam logic [AW:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [AW:0] WIN_HI = WIN_LO + ((AW+1)'(1) << (RAM_AW + 2));
    assign addr_err = ({1'b0, icb_cmd_addr} <  WIN_LO) |
                      ({1'b0, icb_cmd_addr} >= WIN_HI);
`else
    assign addr_err = 1'b0;
`endif

    // Byte offset and (in the default build) the upper bits do not select a word.
    logic unused_addr;
    assign unused_addr = ^{icb_cmd_addr[AW-1:RAM_AW+2], icb_cmd_addr[1:0], BASE_ADDR};

    assign ram_we = ~icb_cmd_read & ~addr_err;

    e203_sysmem_ram_sp #(
        .AW (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .cs   (cmd_fire),
        .we   (ram_we),
        .wem  (icb_cmd_wmask),
        .addr (icb_cmd_addr[RAM_AW+1:2]),
        .din  (icb_cmd_wdata),
        .dout (ram_dout)
    );

    // Writes and errored commands answer with zero data.
    always_comb begin
        pend_entry.err   = pend_err_q;
        pend_entry.rdata = (pend_q & pend_read_q & ~pend_err_q) ? ram_dout : '0;
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(RSP_DEPTH));

    // The FIFO holds older responses than the pending stage, so it has priority.
    assign head_entry    = fifo_empty ? pend_entry : fifo_mem[rptr_q];
    assign icb_rsp_valid = ~fifo_empty | pend_q;
    assign icb_rsp_err   = head_entry.err;
    assign icb_rsp_rdata = head_entry.rdata;

    assign rsp_fire  = icb_rsp_valid & icb_rsp_ready;
    assign fifo_pop  = rsp_fire & ~fifo_empty;
    // The pending entry bypasses the FIFO only when it is the head and is taken now.
    assign fifo_push = pend_q & ~(fifo_empty & icb_rsp_ready);

    always_comb begin
        credit_d = credit_q;
        if (cmd_fire && !rsp_fire) begin
            credit_d = credit_q + CW'(1);
        end else if (!cmd_fire && rsp_fire) begin
            credit_d = credit_q - CW'(1);
        end

        cnt_d = cnt_q;
        if (fifo_push && !fifo_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!fifo_push && fifo_pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        wptr_d = wptr_q;
        if (fifo_push) begin
            wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end

        rptr_d = rptr_q;
        if (fifo_pop) begin
            rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end

        pend_d      = cmd_fire;
        pend_read_d = cmd_fire & icb_cmd_read;
        pend_err_d  = cmd_fire & addr_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q    <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pend_q      <= 1'b0;
            pend_read_q <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pend_q      <= pend_d;
            pend_read_q <= pend_read_d;
            pend_err_q  <= pend_err_d;
        end
    end

    // Storage only; validity is tracked by cnt_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wptr_q] <= pend_entry;
        end
    end

    // Credit limiting must make overflow impossible (a pop in the same cycle frees a slot).
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
